// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
package onehot_decoder_seq_pkg;

  // Controller states kept as plain constants so older tools and netlists
  // see a fixed 2-bit encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HOLD = 2'd1;
  localparam state_t ST_SCAN = 2'd2;

  // Widest output word any instance may request; callers cast the result
  // of onehot() down to their own OUT_W.
  localparam int unsigned MAX_OUT_W = 256;
  typedef logic [MAX_OUT_W-1:0] onehot_t;

  // One-hot image of code within a word of the given width; codes at or
  // beyond the width yield all zeros.
  function automatic onehot_t onehot(input int unsigned code, input int unsigned width);
    onehot_t r;
    r = '0;
    if ((code < width) && (code < MAX_OUT_W)) r[code[7:0]] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_scan_counter.sv
// Modulo-OUT_W index counter with clear, parallel load and a registered
// wrap pulse. count_nxt is exposed so the caller can register a decoded
// image of the index in the same cycle as the index itself.
module onehot_decoder_seq_scan_counter #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic             inc,
  output logic [SEL_W-1:0] count,
  output logic [SEL_W-1:0] count_nxt,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(OUT_W - 1);

  logic wrap_nxt;

  // Next index: clear beats load beats increment; wrap only on LAST -> 0.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_val;
    end else if (inc) begin
      if (count == LAST) begin
        count_nxt = '0;
        wrap_nxt  = 1'b1;
      end else begin
        count_nxt = count + SEL_W'(1);
      end
    end
  end

  // Index and wrap registers; wrap lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered, parametrised one-hot decoder with valid/ready select input
// and a stepped scan mode that walks one active line across all outputs.
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned OUT_W   = 8,
  parameter bit          ACT_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             step,
  output logic [OUT_W-1:0] dec_out,
  output logic [SEL_W-1:0] idx,
  output logic             out_valid,
  output logic             err,
  output logic             wrap
);

  state_t           state_p1;
  logic [OUT_W-1:0] dec_p1;
  logic             vld_p1;
  logic             err_p1;

  logic             accept;
  logic             in_range;
  logic             scan_entry;
  logic             scan_step;
  logic [SEL_W-1:0] cnt_nxt;
  logic [OUT_W-1:0] oh_nxt;

  assign in_ready   = rst_n & en & ~mode;
  assign accept     = in_valid & in_ready;
  assign in_range   = (32'(sel) < OUT_W);
  assign scan_entry = en & mode & (state_p1 != ST_SCAN);
  assign scan_step  = en & mode & (state_p1 == ST_SCAN) & step;

  // Decoded image of whatever index the counter is about to hold; out of
  // range selects never load the counter, so this is only used when legal.
  assign oh_nxt = OUT_W'(onehot(32'(cnt_nxt), OUT_W));

  onehot_decoder_seq_scan_counter #(
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_scan_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (scan_entry),
    .load      (accept & in_range),
    .load_val  (sel),
    .inc       (scan_step),
    .count     (idx),
    .count_nxt (cnt_nxt),
    .wrap      (wrap)
  );

  // Control and registered output word: reset > enable > mode > accept/step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= ST_IDLE;
      dec_p1   <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else if (!en) begin
      state_p1 <= ST_IDLE;
      dec_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (mode) begin
      if (state_p1 != ST_SCAN) begin
        state_p1 <= ST_SCAN;
        dec_p1   <= oh_nxt;
        vld_p1   <= 1'b1;
        err_p1   <= 1'b0;
      end else if (step) begin
        dec_p1   <= oh_nxt;
      end
    end else if (accept) begin
      state_p1 <= ST_HOLD;
      if (in_range) begin
        dec_p1 <= oh_nxt;
        vld_p1 <= 1'b1;
        err_p1 <= 1'b0;
      end else begin
        dec_p1 <= '0;
        vld_p1 <= 1'b0;
        err_p1 <= 1'b1;
      end
    end else if (state_p1 == ST_SCAN) begin
      state_p1 <= ST_IDLE;
      dec_p1   <= '0;
      vld_p1   <= 1'b0;
    end
  end

  assign dec_out   = ACT_LOW ? ~dec_p1 : dec_p1;
  assign out_valid = vld_p1;
  assign err       = err_p1;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: three instances (8 lines, 6 lines,
// 8 lines active-low) share one stimulus stream and are compared against
// an index/validity model written straight from the behavioural rules.
module tb_onehot_decoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, mode, in_valid, step;
  logic [2:0] sel;

  logic [7:0] dec8, decl;
  logic [5:0] dec6;
  logic [2:0] idx8, idx6, idxl;
  logic       rdy8, rdy6, rdyl;
  logic       ov8, ov6, ovl, err8, err6, errl, wr8, wr6, wrl;

  onehot_decoder_seq #(.SEL_W(3), .OUT_W(8), .ACT_LOW(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy8), .sel(sel), .step(step), .dec_out(dec8), .idx(idx8),
    .out_valid(ov8), .err(err8), .wrap(wr8));

  onehot_decoder_seq #(.SEL_W(3), .OUT_W(6), .ACT_LOW(1'b0)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy6), .sel(sel), .step(step), .dec_out(dec6), .idx(idx6),
    .out_valid(ov6), .err(err6), .wrap(wr6));

  onehot_decoder_seq #(.SEL_W(3), .OUT_W(8), .ACT_LOW(1'b1)) dutl (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdyl), .sel(sel), .step(step), .dec_out(decl), .idx(idxl),
    .out_valid(ovl), .err(errl), .wrap(wrl));

  // Uniform views of the three instances.
  logic [7:0] o_dec [3];
  logic [2:0] o_idx [3];
  logic       o_rdy [3], o_ov [3], o_err [3], o_wr [3];
  assign o_dec[0] = dec8;          assign o_dec[1] = {2'b00, dec6}; assign o_dec[2] = decl;
  assign o_idx[0] = idx8;          assign o_idx[1] = idx6;          assign o_idx[2] = idxl;
  assign o_rdy[0] = rdy8;          assign o_rdy[1] = rdy6;          assign o_rdy[2] = rdyl;
  assign o_ov[0]  = ov8;           assign o_ov[1]  = ov6;           assign o_ov[2]  = ovl;
  assign o_err[0] = err8;          assign o_err[1] = err6;          assign o_err[2] = errl;
  assign o_wr[0]  = wr8;           assign o_wr[1]  = wr6;           assign o_wr[2]  = wrl;

  int cfg_w  [3] = '{8, 6, 8};
  bit cfg_al [3] = '{1'b0, 1'b0, 1'b1};

  // Reference model: which line is active, whether it is shown, and flags.
  int m_idx   [3];
  bit m_valid [3], m_err [3], m_wrap [3], m_scan [3];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_dec(input int i);
    logic [7:0] v;
    v = m_valid[i] ? 8'(1 << m_idx[i]) : 8'h00;
    if (cfg_al[i]) v = ~v & 8'((1 << cfg_w[i]) - 1);
    return v;
  endfunction

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_scan[i] = 0; m_valid[i] = 0; m_idx[i] = 0; m_err[i] = 0; m_wrap[i] = 0;
      end else if (!en) begin
        m_scan[i] = 0; m_valid[i] = 0; m_wrap[i] = 0;
      end else if (mode) begin
        m_wrap[i] = 0;
        if (!m_scan[i]) begin
          m_scan[i] = 1; m_idx[i] = 0; m_valid[i] = 1; m_err[i] = 0;
        end else if (step) begin
          m_wrap[i] = (m_idx[i] + 1 == cfg_w[i]);
          m_idx[i]  = (m_idx[i] + 1) % cfg_w[i];
        end
      end else begin
        m_wrap[i] = 0;
        if (in_valid) begin
          if (int'(sel) < cfg_w[i]) begin
            m_idx[i] = int'(sel); m_valid[i] = 1; m_err[i] = 0;
          end else begin
            m_valid[i] = 0; m_err[i] = 1;
          end
        end else if (m_scan[i]) begin
          m_valid[i] = 0;
        end
        m_scan[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d.dec_out", i),   32'(o_dec[i]), 32'(exp_dec(i)));
      check($sformatf("dut%0d.idx", i),       32'(o_idx[i]), 32'(m_idx[i]));
      check($sformatf("dut%0d.out_valid", i), 32'(o_ov[i]),  32'(m_valid[i]));
      check($sformatf("dut%0d.err", i),       32'(o_err[i]), 32'(m_err[i]));
      check($sformatf("dut%0d.wrap", i),      32'(o_wr[i]),  32'(m_wrap[i]));
    end
  endtask

  // Apply one cycle of inputs, check in_ready, clock, then check outputs.
  task automatic drive(input bit r, input bit e, input bit m, input bit v,
                       input logic [2:0] s, input bit st);
    rst_n = r; en = e; mode = m; in_valid = v; sel = s; step = st;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("dut%0d.in_ready", i), 32'(o_rdy[i]), 32'(r & e & ~m));
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    bit r_m;
    rst_n = 0; en = 0; mode = 0; in_valid = 0; sel = '0; step = 0;

    // Reset for two cycles.
    drive(0, 1, 0, 1, 3'd5, 0);
    drive(0, 1, 0, 1, 3'd5, 0);
    check("reset.dec8", 32'(dec8), 32'h00);
    check("reset.decl", 32'(decl), 32'hFF);

    // First accept after reset.
    drive(1, 1, 0, 1, 3'd5, 0);
    check("first.dec8", 32'(dec8), 32'b0010_0000);
    check("first.idx8", 32'(idx8), 32'd5);

    // Back-to-back accept of every select code.
    for (int s = 0; s < 8; s++) begin
      drive(1, 1, 0, 1, 3'(s), 0);
      check($sformatf("direct%0d.dec8", s), 32'(dec8), 32'(1 << s));
      check($sformatf("direct%0d.ones", s), 32'($countones(dec8)), 32'd1);
    end
    // sel=7 ended the loop: out of range for the 6-line instance.
    check("range.dec6", 32'(dec6), 32'h0);
    check("range.err6", 32'(err6), 32'd1);
    drive(1, 1, 0, 1, 3'd2, 0);
    check("range2.dec6", 32'(dec6), 32'b000100);
    check("range2.err6", 32'(err6), 32'd0);

    // Scan entry with in_valid asserted (not accepted), then 8 steps.
    drive(1, 1, 1, 1, 3'd6, 0);
    check("scan_entry.idx8", 32'(idx8), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 1, 1, 3'(k), 1);
      check($sformatf("scan%0d.idx8", k),  32'(idx8), 32'((k + 1) % 8));
      check($sformatf("scan%0d.wrap8", k), 32'(wr8),  32'(k == 7));
    end
    drive(1, 1, 1, 0, 3'd0, 0);
    check("scan_hold.wrap8", 32'(wr8), 32'd0);

    // Leave scan, active-low accept, then disable.
    drive(1, 1, 0, 0, 3'd0, 0);
    drive(1, 1, 0, 1, 3'd3, 0);
    check("actlow.decl", 32'(decl), 32'b1111_0111);
    drive(1, 0, 0, 1, 3'd3, 0);
    check("disable.decl", 32'(decl), 32'hFF);
    check("disable.ovl", 32'(ovl), 32'd0);

    // Reset mid-scan at idx 4, then re-enter scan.
    drive(1, 1, 1, 0, 3'd0, 0);
    for (int k = 0; k < 4; k++) drive(1, 1, 1, 0, 3'd0, 1);
    check("midscan.idx8", 32'(idx8), 32'd4);
    drive(0, 1, 1, 0, 3'd0, 1);
    check("midscan_rst.dec8", 32'(dec8), 32'h00);
    check("midscan_rst.idx8", 32'(idx8), 32'd0);
    drive(1, 1, 1, 0, 3'd0, 1);
    check("rescan.idx8", 32'(idx8), 32'd0);

    // Randomized traffic against the model.
    r_m = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) r_m = ~r_m;
      drive($urandom_range(0, 59) != 0, $urandom_range(0, 11) != 0, r_m,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
